// File: rtl/ahb_slave_scratchpad.sv
// AHB-Lite scratchpad responder: word-organised RAM with byte/halfword/word
// write strobes, configurable OKAY wait states and a two-cycle ERROR response.
module ahb_slave_scratchpad #(
   parameter int unsigned NWORDS      = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic        HMASTLOCK,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic        HREADYOUT,
   output logic [1:0]  HRESP,
   output logic [31:0] HRDATA
);

   localparam int unsigned AW      = $clog2(NWORDS);
   localparam logic [31:0] SPAN    = 32'(NWORDS * 4);
   localparam logic [2:0]  WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_e;

   state_e          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            write_q, write_d;
   logic [1:0]      size_q, size_d;
   logic [1:0]      lane_q, lane_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [31:0]     mem [NWORDS];

   logic [31:0]     off;
   logic            addr_err;
   logic            accept;
   logic [3:0]      strobe;
   logic            unused_inputs;

   assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

   // Only states that drive HREADYOUT high can see a new address phase.
   always_comb begin
      off      = HADDR - BASE_ADDR;
      addr_err = (off >= SPAN) || (HSIZE > 3'd2) ||
                 (HSIZE == 3'd1 && HADDR[0]) ||
                 (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
      accept   = HSEL && HREADY && HTRANS[1] &&
                 (state_q == ST_IDLE || state_q == ST_DATA || state_q == ST_ERR2);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      size_d  = size_q;
      lane_d  = lane_q;
      idx_d   = idx_q;
      case (state_q)
         ST_WAIT: begin
            if (cnt_q == 3'd0) state_d = ST_DATA;
            else               cnt_d   = cnt_q - 3'd1;
         end
         ST_ERR1: state_d = ST_ERR2;
         default: begin
            state_d = ST_IDLE;
            if (accept) begin
               write_d = HWRITE;
               size_d  = HSIZE[1:0];
               lane_d  = HADDR[1:0];
               idx_d   = off[AW+1:2];
               if (addr_err) begin
                  state_d = ST_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WS_LOAD;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
         lane_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         size_q  <= size_d;
         lane_q  <= lane_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      case (size_q)
         2'd0:    strobe = 4'b0001 << lane_q;
         2'd1:    strobe = lane_q[1] ? 4'b1100 : 4'b0011;
         default: strobe = 4'b1111;
      endcase
   end

   // Memory is not reset; a write in flight when RST rises is dropped.
   always_ff @(posedge CLK) begin
      if (!RST && state_q == ST_DATA && write_q) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (strobe[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
         end
      end
   end

   always_comb begin
      HREADYOUT = !(state_q == ST_WAIT || state_q == ST_ERR1);
      HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? 2'b01 : 2'b00;
      HRDATA    = (!write_q && (state_q == ST_WAIT || state_q == ST_DATA)) ? mem[idx_q] : '0;
   end

endmodule

// File: tb/tb_ahb_slave_scratchpad.sv
// Randomised bench for ahb_slave_scratchpad: three instances with different
// depth/base/wait-state settings share one bus, checked against a transfer-level model.
module tb_ahb_slave_scratchpad;

   localparam int NI = 3;
   localparam logic [31:0] BASE0 = 32'h0000_1000;
   localparam logic [31:0] BASE1 = 32'h0002_0000;
   localparam logic [31:0] BASE2 = 32'h8000_0000;
   localparam int LIMIT = 40000;

   logic [31:0] base_a [NI] = '{BASE0, BASE1, BASE2};
   int          nw_a   [NI] = '{64, 16, 4};
   int          ws_a   [NI] = '{0, 3, 2};

   logic          clk = 1'b0;
   logic          rst;
   logic [NI-1:0] hsel;
   logic [31:0]   haddr, hwdata;
   logic [1:0]    htrans;
   logic          hwrite, hmastlock, hready;
   logic [2:0]    hsize, hburst;
   logic [3:0]    hprot;
   logic          hreadyout [NI];
   logic [1:0]    hresp     [NI];
   logic [31:0]   hrdata    [NI];

   always #5 clk = ~clk;

   ahb_slave_scratchpad #(.NWORDS(64), .BASE_ADDR(BASE0), .WAIT_STATES(0)) u_dut0 (
      .CLK(clk), .RST(rst), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HMASTLOCK(hmastlock), .HREADY(hready), .HWDATA(hwdata),
      .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

   ahb_slave_scratchpad #(.NWORDS(16), .BASE_ADDR(BASE1), .WAIT_STATES(3)) u_dut1 (
      .CLK(clk), .RST(rst), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HMASTLOCK(hmastlock), .HREADY(hready), .HWDATA(hwdata),
      .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

   ahb_slave_scratchpad #(.NWORDS(4), .BASE_ADDR(BASE2), .WAIT_STATES(2)) u_dut2 (
      .CLK(clk), .RST(rst), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HMASTLOCK(hmastlock), .HREADY(hready), .HWDATA(hwdata),
      .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]), .HRDATA(hrdata[2]));

   // kind 0 = bus address phase, kind 1 = one cycle of reset
   typedef struct {
      int          kind;
      int          inst;
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [1:0]  trans;
      logic        sel;
      logic [31:0] wdata;
   } item_t;

   item_t       stim_q [$];
   logic [31:0] mem_m [NI][64];
   int          n_cmp = 0;
   int          n_bad = 0;

   item_t dp, ap;
   bit    dp_valid, dp_err, last_acc;
   int    dp_cnt, cyc;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic item_t mk(int inst, logic [31:0] addr, logic wr, logic [2:0] size,
                                logic [31:0] wdata, logic [1:0] trans = 2'b10, logic sel = 1'b1);
      item_t it;
      it.kind = 0; it.inst = inst; it.addr = addr; it.wr = wr; it.size = size;
      it.trans = trans; it.sel = sel; it.wdata = wdata;
      return it;
   endfunction

   function automatic item_t mk_idle();
      return mk(0, $urandom, 1'b0, 3'd0, 32'd0, 2'b00, 1'b0);
   endfunction

   function automatic item_t mk_rst();
      item_t it = mk_idle();
      it.kind = 1;
      return it;
   endfunction

   function automatic bit is_err(item_t it);
      logic [31:0] off = it.addr - base_a[it.inst];
      return (off >= 32'(nw_a[it.inst] * 4)) || (it.size > 3'd2) ||
             (it.size == 3'd1 && it.addr[0]) ||
             (it.size == 3'd2 && it.addr[1:0] != 2'b00);
   endfunction

   function automatic int word_of(item_t it);
      logic [31:0] off = it.addr - base_a[it.inst];
      return int'(off >> 2);
   endfunction

   task automatic commit(input item_t it);
      int w = word_of(it);
      int lane = int'(it.addr[1:0]);
      int hl = int'(it.addr[1]) * 2;
      case (it.size)
         3'd0:    mem_m[it.inst][w][8*lane +: 8] = it.wdata[8*lane +: 8];
         3'd1:    mem_m[it.inst][w][8*hl +: 16] = it.wdata[8*hl +: 16];
         default: mem_m[it.inst][w] = it.wdata;
      endcase
   endtask

   function automatic bit exp_ready();
      if (!dp_valid) return 1'b1;
      if (dp_err)    return dp_cnt == 1;
      return dp_cnt >= ws_a[dp.inst];
   endfunction

   task automatic check_outputs();
      for (int k = 0; k < NI; k++) begin
         logic        er = 1'b1;
         logic [1:0]  eresp = 2'b00;
         logic [31:0] edata = 32'd0;
         if (dp_valid && dp.inst == k) begin
            er = exp_ready();
            if (dp_err) eresp = 2'b01;
            else if (!dp.wr) edata = mem_m[k][word_of(dp)];
         end
         check_eq($sformatf("i%0d.hreadyout", k), 32'(hreadyout[k]), 32'(er));
         check_eq($sformatf("i%0d.hresp", k), 32'(hresp[k]), 32'(eresp));
         check_eq($sformatf("i%0d.hrdata", k), hrdata[k], edata);
      end
   endtask

   function automatic item_t rand_item();
      int          k = $urandom_range(0, NI - 1);
      int          r = $urandom_range(0, 9);
      int          t = $urandom_range(0, 9);
      logic [31:0] a;
      logic [2:0]  sz;
      logic [1:0]  tr;
      if ($urandom_range(0, 60) == 0) return mk_rst();
      sz = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      if (r == 0)      a = base_a[k] + 32'(nw_a[k] * 4) + 32'($urandom_range(0, 15));
      else if (r == 1) a = base_a[k] - 32'($urandom_range(1, 8));
      else begin
         a = base_a[k] + 32'($urandom_range(0, nw_a[k] * 4 - 1));
         if (r > 3 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
      end
      tr = (t == 0) ? 2'b00 : (t == 1) ? 2'b01 : (t < 6) ? 2'b10 : 2'b11;
      return mk(k, a, 1'($urandom), sz, $urandom, tr, $urandom_range(0, 9) != 0);
   endfunction

   initial begin
      rst = 1'b1; hsel = '0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
      hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; hmastlock = 1'b0;
      hready = 1'b1; hwdata = '0;
      dp_valid = 0; dp_err = 0; dp_cnt = 0; last_acc = 1; cyc = 0;

      for (int k = 0; k < NI; k++)
         for (int w = 0; w < nw_a[k]; w++)
            stim_q.push_back(mk(k, base_a[k] + 32'(4 * w), 1'b1, 3'd2, $urandom));

      stim_q.push_back(mk(0, BASE0 + 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF));
      stim_q.push_back(mk(0, BASE0 + 32'h10, 1'b0, 3'd2, 32'h0));
      for (int b = 0; b < 4; b++)
         stim_q.push_back(mk(0, BASE0 + 32'h20 + 32'(b), 1'b1, 3'd0,
                             (32'h11 * 32'(b + 1)) << (8 * b), 2'b11));
      stim_q.push_back(mk(0, BASE0 + 32'h22, 1'b1, 3'd1, 32'hAAAA_0000));
      stim_q.push_back(mk(0, BASE0 + 32'h20, 1'b0, 3'd2, 32'h0));
      stim_q.push_back(mk_idle());
      stim_q.push_back(mk(1, BASE1 + 32'h4, 1'b0, 3'd2, 32'h0));
      stim_q.push_back(mk_idle());
      stim_q.push_back(mk(1, BASE1 + 32'h8, 1'b1, 3'd2, 32'h1234_5678));
      stim_q.push_back(mk(1, BASE1 + 32'hC, 1'b1, 3'd2, 32'h9ABC_DEF0, 2'b11));
      stim_q.push_back(mk_idle());
      for (int k = 0; k < 2; k++) begin
         stim_q.push_back(mk(k, base_a[k] + 32'(nw_a[k] * 4), 1'b1, 3'd2, $urandom));
         stim_q.push_back(mk(k, base_a[k] + 32'h1, 1'b1, 3'd1, $urandom));
         stim_q.push_back(mk(k, base_a[k], 1'b0, 3'd2, 32'h0));
      end
      stim_q.push_back(mk(0, BASE0 + 32'h4, 1'b1, 3'd2, $urandom, 2'b01));
      stim_q.push_back(mk(0, BASE0 + 32'h4, 1'b1, 3'd2, $urandom, 2'b00));
      stim_q.push_back(mk(0, BASE0 + 32'h4, 1'b1, 3'd2, $urandom, 2'b10, 1'b0));
      stim_q.push_back(mk(0, BASE0 + 32'h4, 1'b0, 3'd2, 32'h0));
      stim_q.push_back(mk(2, BASE2 + 32'h8, 1'b1, 3'd2, 32'hCAFE_F00D));
      stim_q.push_back(mk_rst());
      stim_q.push_back(mk_idle());
      stim_q.push_back(mk(2, BASE2 + 32'h8, 1'b0, 3'd2, 32'h0));
      for (int n = 0; n < 700; n++) stim_q.push_back(rand_item());

      repeat (3) @(negedge clk);
      check_outputs();

      while (cyc < LIMIT && (stim_q.size() != 0 || dp_valid || !last_acc)) begin
         bit ready_now;
         check_outputs();
         ready_now = exp_ready();
         if (last_acc) ap = (stim_q.size() != 0) ? stim_q.pop_front() : mk_idle();
         rst    = (ap.kind == 1);
         hsel   = (ap.kind == 0 && ap.sel) ? NI'(1 << ap.inst) : '0;
         haddr  = ap.addr;
         htrans = ap.trans;
         hwrite = ap.wr;
         hsize  = ap.size;
         hburst = 3'($urandom);
         hprot  = 4'($urandom);
         hmastlock = 1'($urandom);
         hready = ready_now;
         hwdata = dp_valid ? dp.wdata : $urandom;
         if (ap.kind == 1) begin
            dp_valid = 0;
            last_acc = 1;
         end else if (ready_now) begin
            if (dp_valid && dp.wr && !dp_err) commit(dp);
            dp       = ap;
            dp_valid = ap.sel && ap.trans[1];
            dp_err   = is_err(ap);
            dp_cnt   = 0;
            last_acc = 1;
         end else begin
            dp_cnt++;
            last_acc = 0;
         end
         @(negedge clk);
         cyc++;
      end
      check_outputs();
      check_eq("drain", 32'(stim_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
